cushion_arb: RTL and testbench

- Parametrised successor of the single-coprocessor cushion stage.
- Sits between the execute units (main plus COP_NUMS coprocessors) and the memory/writeback stage.
- Collects results from every unit an instruction was issued to. Units may complete in different cycles.
- Stalls upstream while results are outstanding, then emits exactly one merged commit record, with exception-priority merging and an optional watchdog timeout.

---
 rtl/cushion_arb.sv | 205 ++++++++++++++++++++
 tb/tb_cushion_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cushion_arb.sv
// cushion_arb: gathers results from every execute channel an instruction was issued to,
// stalls upstream meanwhile, then emits one merged commit record. Watchdog: CUSHION_TIMEOUT_EN.
module cushion_arb #(
  parameter int         COP_NUMS     = 2,
  parameter int         PNUMS        = COP_NUMS + 1,
  parameter int         SIDE_W       = 160,
  parameter int         TIMEOUT      = 16,
  parameter logic [3:0] TIMEOUT_CODE = 4'd2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                MMU_WAIT,
  input  logic                ISSUE_EN,
  input  logic [PNUMS-1:0]    ISSUE_MASK,
  input  logic [31:0]         ISSUE_PC,
  input  logic [PNUMS-1:0]    RES_VALID,
  input  logic [PNUMS-1:0]    RES_REG_W_EN,
  input  logic [5*PNUMS-1:0]  RES_REG_W_RD,
  input  logic [32*PNUMS-1:0] RES_REG_W_DATA,
  input  logic [PNUMS-1:0]    RES_EXC_EN,
  input  logic [4*PNUMS-1:0]  RES_EXC_CODE,
  input  logic [SIDE_W-1:0]   MAIN_SIDE,
  output logic                STALL,
  output logic                CUSHION_VALID,
  output logic [31:0]         CUSHION_PC,
  output logic                CUSHION_REG_W_EN,
  output logic [4:0]          CUSHION_REG_W_RD,
  output logic [31:0]         CUSHION_REG_W_DATA,
  output logic                CUSHION_EXC_EN,
  output logic [3:0]          CUSHION_EXC_CODE,
  output logic [SIDE_W-1:0]   CUSHION_SIDE,
  output logic [PNUMS-1:0]    CUSHION_SRC
);

  // state | meaning
  // IDLE  | nothing outstanding; accepts an issue
  // WAIT  | collecting results from pending channels; upstream stalled
  // DONE  | merged record on CUSHION_*; accepts a back-to-back issue
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             to_fire;
  logic             timed_out;
  logic             timer_hit;
  logic [PNUMS-1:0] pending;
  logic [PNUMS-1:0] captured;
  logic [PNUMS-1:0] cap_now;
  logic [PNUMS-1:0] pending_post;
  logic [31:0]      pc;
  logic [SIDE_W-1:0] side;

  logic             hold_w_en     [PNUMS];
  logic [4:0]       hold_rd       [PNUMS];
  logic [31:0]      hold_data     [PNUMS];
  logic             hold_exc_en   [PNUMS];
  logic [3:0]       hold_exc_code [PNUMS];

  logic             exc_hit;
  logic             w_hit;

  // Capture is independent of MMU_WAIT so a frozen pipeline never drops a result.
  assign cap_now      = (state == S_WAIT) ? (RES_VALID & pending) : '0;
  assign pending_post = pending & ~cap_now;

`ifdef CUSHION_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;

  assign timer_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      timer <= '0;
    end else if (!MMU_WAIT) begin
      if (state != S_WAIT) timer <= '0;
      else                 timer <= timer + 1'b1;
    end
  end
`else
  // Watchdog compiled out: never fires.
  assign timer_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    to_fire   = 1'b0;
    if (!MMU_WAIT) begin
      case (state)
        S_WAIT: begin
          if (pending_post == '0) begin
            state_nxt = S_DONE;
          end else if (timer_hit) begin
            state_nxt = S_DONE;
            to_fire   = 1'b1;
          end
        end
        default: begin
          if (ISSUE_EN) begin
            accept    = 1'b1;
            state_nxt = (ISSUE_MASK == '0) ? S_DONE : S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      pending   <= '0;
      captured  <= '0;
      pc        <= '0;
      side      <= '0;
      timed_out <= 1'b0;
      for (int i = 0; i < PNUMS; i++) begin
        hold_w_en[i]     <= 1'b0;
        hold_rd[i]       <= '0;
        hold_data[i]     <= '0;
        hold_exc_en[i]   <= 1'b0;
        hold_exc_code[i] <= '0;
      end
    end else begin
      pending <= pending_post;
      for (int i = 0; i < PNUMS; i++) begin
        if (cap_now[i]) begin
          hold_w_en[i]     <= RES_REG_W_EN[i];
          hold_rd[i]       <= RES_REG_W_RD[5*i +: 5];
          hold_data[i]     <= RES_REG_W_DATA[32*i +: 32];
          hold_exc_en[i]   <= RES_EXC_EN[i];
          hold_exc_code[i] <= RES_EXC_CODE[4*i +: 4];
          captured[i]      <= 1'b1;
        end
      end
      if (cap_now[0]) side <= MAIN_SIDE;
      if (to_fire)    timed_out <= 1'b1;
      if (accept) begin
        pc        <= ISSUE_PC;
        pending   <= ISSUE_MASK;
        captured  <= '0;
        timed_out <= 1'b0;
      end
    end
  end

  // Exceptions outrank register writes; within each class the lowest channel wins.
  always_comb begin
    STALL              = (state == S_WAIT);
    CUSHION_VALID      = 1'b0;
    CUSHION_PC         = '0;
    CUSHION_REG_W_EN   = 1'b0;
    CUSHION_REG_W_RD   = '0;
    CUSHION_REG_W_DATA = '0;
    CUSHION_EXC_EN     = 1'b0;
    CUSHION_EXC_CODE   = '0;
    CUSHION_SIDE       = '0;
    CUSHION_SRC        = '0;
    exc_hit            = 1'b0;
    w_hit              = 1'b0;
    if (state == S_DONE) begin
      CUSHION_VALID = 1'b1;
      CUSHION_PC    = pc;
      CUSHION_SIDE  = captured[0] ? side : '0;
      if (timed_out) begin
        CUSHION_EXC_EN   = 1'b1;
        CUSHION_EXC_CODE = TIMEOUT_CODE;
      end else begin
        for (int i = 0; i < PNUMS; i++) begin
          if (!exc_hit && captured[i] && hold_exc_en[i]) begin
            exc_hit          = 1'b1;
            CUSHION_EXC_EN   = 1'b1;
            CUSHION_EXC_CODE = hold_exc_code[i];
            CUSHION_SRC[i]   = 1'b1;
          end
        end
        if (!exc_hit) begin
          for (int i = 0; i < PNUMS; i++) begin
            if (!w_hit && captured[i] && hold_w_en[i]) begin
              w_hit              = 1'b1;
              CUSHION_REG_W_EN   = 1'b1;
              CUSHION_REG_W_RD   = hold_rd[i];
              CUSHION_REG_W_DATA = hold_data[i];
              CUSHION_SRC[i]     = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cushion_arb.sv
// Bench for cushion_arb: every cycle is compared against a behavioural commit model,
// and directed scenarios pin the observed records to hand-computed literals.
module tb_cushion_arb;
  localparam int         COP_NUMS = 2;
  localparam int         PNUMS    = COP_NUMS + 1;
  localparam int         SIDE_W   = 160;
  localparam int         TIMEOUT  = 4;
  localparam logic [3:0] TO_CODE  = 4'd2;

  logic                CLK = 1'b0;
  logic                RST, FLUSH, MMU_WAIT, ISSUE_EN;
  logic [PNUMS-1:0]    ISSUE_MASK;
  logic [31:0]         ISSUE_PC;
  logic [PNUMS-1:0]    RES_VALID, RES_REG_W_EN, RES_EXC_EN;
  logic [5*PNUMS-1:0]  RES_REG_W_RD;
  logic [32*PNUMS-1:0] RES_REG_W_DATA;
  logic [4*PNUMS-1:0]  RES_EXC_CODE;
  logic [SIDE_W-1:0]   MAIN_SIDE;
  logic                STALL, CUSHION_VALID, CUSHION_REG_W_EN, CUSHION_EXC_EN;
  logic [31:0]         CUSHION_PC, CUSHION_REG_W_DATA;
  logic [4:0]          CUSHION_REG_W_RD;
  logic [3:0]          CUSHION_EXC_CODE;
  logic [SIDE_W-1:0]   CUSHION_SIDE;
  logic [PNUMS-1:0]    CUSHION_SRC;

  cushion_arb #(
    .COP_NUMS(COP_NUMS), .PNUMS(PNUMS), .SIDE_W(SIDE_W),
    .TIMEOUT(TIMEOUT), .TIMEOUT_CODE(TO_CODE)
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
    .ISSUE_EN(ISSUE_EN), .ISSUE_MASK(ISSUE_MASK), .ISSUE_PC(ISSUE_PC),
    .RES_VALID(RES_VALID), .RES_REG_W_EN(RES_REG_W_EN), .RES_REG_W_RD(RES_REG_W_RD),
    .RES_REG_W_DATA(RES_REG_W_DATA), .RES_EXC_EN(RES_EXC_EN), .RES_EXC_CODE(RES_EXC_CODE),
    .MAIN_SIDE(MAIN_SIDE), .STALL(STALL), .CUSHION_VALID(CUSHION_VALID),
    .CUSHION_PC(CUSHION_PC), .CUSHION_REG_W_EN(CUSHION_REG_W_EN),
    .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
    .CUSHION_EXC_EN(CUSHION_EXC_EN), .CUSHION_EXC_CODE(CUSHION_EXC_CODE),
    .CUSHION_SIDE(CUSHION_SIDE), .CUSHION_SRC(CUSHION_SRC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [SIDE_W-1:0] act, input logic [SIDE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [PNUMS-1:0] v);
    for (int i = 0; i < PNUMS; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: one outstanding instruction with the set of channels still owed and the
  // results already received; a commit is shown for as long as the freeze holds it.
  bit               m_busy = 0, m_commit = 0, m_tmo = 0;
  logic [PNUMS-1:0] m_need = '0, m_got = '0, m_wv = '0, m_ev = '0;
  logic [4:0]       m_rd   [PNUMS];
  logic [31:0]      m_data [PNUMS];
  logic [3:0]       m_code [PNUMS];
  logic [31:0]      m_pc = '0;
  logic [SIDE_W-1:0] m_side = '0;
  int               m_age = 0;

  logic             e_wen, e_exc;
  logic [31:0]      e_pc, e_data;
  logic [4:0]       e_rd;
  logic [3:0]       e_code;
  logic [SIDE_W-1:0] e_side;
  logic [PNUMS-1:0] e_src;

  always @(posedge CLK) begin
    if (RST || FLUSH) begin
      m_busy = 0; m_commit = 0; m_tmo = 0; m_need = '0; m_got = '0; m_age = 0;
    end else begin
      if (m_busy) begin
        for (int i = 0; i < PNUMS; i++) begin
          if (RES_VALID[i] && m_need[i]) begin
            m_need[i] = 1'b0;
            m_got[i]  = 1'b1;
            m_wv[i]   = RES_REG_W_EN[i];
            m_ev[i]   = RES_EXC_EN[i];
            m_rd[i]   = RES_REG_W_RD[5*i +: 5];
            m_data[i] = RES_REG_W_DATA[32*i +: 32];
            m_code[i] = RES_EXC_CODE[4*i +: 4];
            if (i == 0) m_side = MAIN_SIDE;
          end
        end
      end
      if (!MMU_WAIT) begin
        if (m_busy) begin
          if (m_need == '0) begin
            m_busy = 0; m_commit = 1;
          end
`ifdef CUSHION_TIMEOUT_EN
          else if (m_age == TIMEOUT - 1) begin
            m_busy = 0; m_commit = 1; m_tmo = 1;
          end else begin
            m_age++;
          end
`endif
        end else begin
          m_commit = 0;
          if (ISSUE_EN) begin
            m_pc = ISSUE_PC; m_need = ISSUE_MASK; m_got = '0; m_tmo = 0; m_age = 0;
            if (ISSUE_MASK == '0) m_commit = 1;
            else                  m_busy = 1;
          end
        end
      end
    end

    #1;
    e_pc = '0; e_wen = 0; e_rd = '0; e_data = '0; e_exc = 0; e_code = '0; e_side = '0; e_src = '0;
    if (m_commit) begin
      e_pc   = m_pc;
      e_side = m_got[0] ? m_side : '0;
      if (m_tmo) begin
        e_exc = 1; e_code = TO_CODE;
      end else if (first_set(m_got & m_ev) >= 0) begin
        e_exc  = 1;
        e_code = m_code[first_set(m_got & m_ev)];
        e_src  = PNUMS'(1 << first_set(m_got & m_ev));
      end else if (first_set(m_got & m_wv) >= 0) begin
        e_wen  = 1;
        e_rd   = m_rd[first_set(m_got & m_wv)];
        e_data = m_data[first_set(m_got & m_wv)];
        e_src  = PNUMS'(1 << first_set(m_got & m_wv));
      end
    end
    chk("stall", STALL, m_busy);
    chk("valid", CUSHION_VALID, m_commit);
    chk("pc", CUSHION_PC, e_pc);
    chk("reg_w_en", CUSHION_REG_W_EN, e_wen);
    chk("reg_w_rd", CUSHION_REG_W_RD, e_rd);
    chk("reg_w_data", CUSHION_REG_W_DATA, e_data);
    chk("exc_en", CUSHION_EXC_EN, e_exc);
    chk("exc_code", CUSHION_EXC_CODE, e_code);
    chk("side", CUSHION_SIDE, e_side);
    chk("src", CUSHION_SRC, e_src);
    if (CUSHION_VALID) valid_cnt++;
    if (STALL) stall_cnt++;
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic clr_in();
    ISSUE_EN = 0; ISSUE_MASK = '0; FLUSH = 0;
    RES_VALID = '0; RES_REG_W_EN = '0; RES_REG_W_RD = '0; RES_REG_W_DATA = '0;
    RES_EXC_EN = '0; RES_EXC_CODE = '0;
  endtask

  task automatic issue(input logic [PNUMS-1:0] m, input logic [31:0] p);
    ISSUE_EN = 1; ISSUE_MASK = m; ISSUE_PC = p;
  endtask

  task automatic res(input int ch, input logic w, input logic [4:0] rd, input logic [31:0] d,
                     input logic e, input logic [3:0] c);
    RES_VALID[ch] = 1'b1;
    RES_REG_W_EN[ch] = w;
    RES_REG_W_RD[5*ch +: 5] = rd;
    RES_REG_W_DATA[32*ch +: 32] = d;
    RES_EXC_EN[ch] = e;
    RES_EXC_CODE[4*ch +: 4] = c;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int s0, v0, found;
    logic f_exc;
    logic [3:0] f_code;
    logic [PNUMS-1:0] f_src;
    RST = 1; MMU_WAIT = 0; ISSUE_PC = '0; MAIN_SIDE = '0;
    clr_in();
    step(); step();
    chk("reset_valid", CUSHION_VALID, 0);
    chk("reset_stall", STALL, 0);
    RST = 0;
    step();

    // single main-channel result
    s0 = stall_cnt; v0 = valid_cnt;
    issue(3'b001, 32'h100); step(); clr_in();
    MAIN_SIDE = {5{32'hC0FF_EE01}};
    res(0, 1, 5'd5, 32'hDEAD, 0, 4'd0); step(); clr_in();
    chk("t1_valid", CUSHION_VALID, 1);
    chk("t1_pc", CUSHION_PC, 32'h100);
    chk("t1_rd", CUSHION_REG_W_RD, 5'd5);
    chk("t1_data", CUSHION_REG_W_DATA, 32'hDEAD);
    chk("t1_src", CUSHION_SRC, 3'b001);
    chk("t1_side", CUSHION_SIDE, {5{32'hC0FF_EE01}});
    step();
    chk("t1_stall_cycles", stall_cnt - s0, 1);
    chk("t1_valid_cycles", valid_cnt - v0, 1);

    // two coprocessors answering apart; stray ch0 result and issue during WAIT ignored
    s0 = stall_cnt; v0 = valid_cnt;
    issue(3'b110, 32'h140); step(); clr_in();
    res(2, 1, 5'd7, 32'h22, 0, 4'd0);
    res(0, 1, 5'd30, 32'hBAD, 0, 4'd0); step(); clr_in();
    issue(3'b001, 32'h999); step(); clr_in();
    step();
    res(1, 1, 5'd3, 32'h11, 0, 4'd0); step(); clr_in();
    chk("t2_valid", CUSHION_VALID, 1);
    chk("t2_pc", CUSHION_PC, 32'h140);
    chk("t2_rd", CUSHION_REG_W_RD, 5'd3);
    chk("t2_data", CUSHION_REG_W_DATA, 32'h11);
    chk("t2_src", CUSHION_SRC, 3'b010);
    chk("t2_side", CUSHION_SIDE, '0);
    step();
    chk("t2_stall_cycles", stall_cnt - s0, 4);
    chk("t2_valid_cycles", valid_cnt - v0, 1);

    // exception beats a lower-channel register write
    issue(3'b011, 32'h180); step(); clr_in();
    res(0, 1, 5'd9, 32'h99, 0, 4'd0);
    res(1, 0, 5'd0, 32'h0, 1, 4'd3); step(); clr_in();
    chk("t3_exc_en", CUSHION_EXC_EN, 1);
    chk("t3_exc_code", CUSHION_EXC_CODE, 4'd3);
    chk("t3_reg_w_en", CUSHION_REG_W_EN, 0);
    chk("t3_src", CUSHION_SRC, 3'b010);
    step();

    // flush mid-WAIT, late result ignored, then a null commit
    v0 = valid_cnt;
    issue(3'b010, 32'h200); step(); clr_in();
    FLUSH = 1; step(); clr_in();
    res(1, 1, 5'd4, 32'h44, 0, 4'd0); step(); clr_in();
    step();
    chk("t4_no_valid", valid_cnt - v0, 0);
    issue(3'b000, 32'h204); step(); clr_in();
    chk("t4_valid", CUSHION_VALID, 1);
    chk("t4_pc", CUSHION_PC, 32'h204);
    chk("t4_src", CUSHION_SRC, 3'b000);
    chk("t4_reg_w_en", CUSHION_REG_W_EN, 0);
    step();

    // DONE frozen by MMU_WAIT for 3 cycles, then back-to-back issue
    issue(3'b001, 32'h300); step(); clr_in();
    res(0, 1, 5'd1, 32'h1234, 0, 4'd0); step(); clr_in();
    v0 = valid_cnt - 1;
    MMU_WAIT = 1;
    issue(3'b001, 32'h304);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_held_pc", CUSHION_PC, 32'h300);
      chk("t5_held_data", CUSHION_REG_W_DATA, 32'h1234);
    end
    MMU_WAIT = 0;
    step(); clr_in();
    chk("t5_valid_cycles", valid_cnt - v0, 4);
    chk("t5_b2b_stall", STALL, 1);
    res(0, 1, 5'd2, 32'h5678, 0, 4'd0); step(); clr_in();
    chk("t5_b2b_pc", CUSHION_PC, 32'h304);
    chk("t5_b2b_data", CUSHION_REG_W_DATA, 32'h5678);
    step();

    // channel never answers
    issue(3'b100, 32'h400); step(); clr_in();
`ifdef CUSHION_TIMEOUT_EN
    found = 0; f_exc = 0; f_code = '0; f_src = '1;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      if (CUSHION_VALID) begin
        found = k; f_exc = CUSHION_EXC_EN; f_code = CUSHION_EXC_CODE; f_src = CUSHION_SRC;
      end else begin
        step();
      end
    end
    chk("t6_timeout_cycle", found, 5);
    chk("t6_exc_en", f_exc, 1);
    chk("t6_exc_code", f_code, 4'd2);
    chk("t6_src", f_src, 3'b000);
    step();
`else
    found = 0; f_exc = 0; f_code = '0; f_src = '0;
    s0 = stall_cnt;
    repeat (100) step();
    chk("t6_stall_cycles", stall_cnt - s0, 100);
    chk("t6_still_stall", STALL, 1);
    FLUSH = 1; step(); clr_in();
`endif
    chk("t6_idle_stall", STALL, 0);
    chk("t6_idle_valid", CUSHION_VALID, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
